// File: rtl/gdb_run_ctrl_if.sv
// Command / datapath bundle between the GDB stub, the run-control sequencer and the core.
// Watchpoint LSU signals exist only when GDB_RUN_CTRL_WATCH_EN is defined.
interface gdb_run_ctrl_if #(
  parameter int XLEN = 32,
  parameter int BPN  = 4
);
  localparam int IDXW = (BPN > 1) ? $clog2(BPN) : 1;

  logic            cmd_vld;
  logic            cmd_rdy;
  logic [2:0]      cmd_op;
  logic [IDXW-1:0] cmd_idx;
  logic [XLEN-1:0] cmd_adr;
  logic            cpu_en;
  logic            ifu_trn;
  logic [XLEN-1:0] ifu_adr;
  logic            halted;
  logic            evt_vld;
  logic [1:0]      evt_rsn;
  logic [XLEN-1:0] evt_adr;
  logic [XLEN-1:0] icnt;
`ifdef GDB_RUN_CTRL_WATCH_EN
  logic            lsu_trn;
  logic            lsu_wen;
  logic [XLEN-1:0] lsu_adr;
`endif

  // master: stub plus core side; slave: the sequencer
  modport master (
`ifdef GDB_RUN_CTRL_WATCH_EN
    output lsu_trn, lsu_wen, lsu_adr,
`endif
    output cmd_vld, cmd_op, cmd_idx, cmd_adr, ifu_trn, ifu_adr,
    input  cmd_rdy, cpu_en, halted, evt_vld, evt_rsn, evt_adr, icnt
  );

  modport slave (
`ifdef GDB_RUN_CTRL_WATCH_EN
    input  lsu_trn, lsu_wen, lsu_adr,
`endif
    input  cmd_vld, cmd_op, cmd_idx, cmd_adr, ifu_trn, ifu_adr,
    output cmd_rdy, cpu_en, halted, evt_vld, evt_rsn, evt_adr, icnt
  );
endinterface

// File: rtl/gdb_run_ctrl.sv
// Run-control sequencer: halt/continue/step, hardware breakpoints, stop events to the GDB stub.
// Define GDB_RUN_CTRL_WATCH_EN to add store watchpoints on the LSU port.
module gdb_run_ctrl #(
  parameter int XLEN = 32,
  parameter int BPN  = 4
) (
  input logic           clk,
  input logic           rst,
  gdb_run_ctrl_if.slave io_bus
);
  localparam int IDXW = (BPN > 1) ? $clog2(BPN) : 1;

  typedef enum logic [1:0] {ST_HALTED, ST_RUNNING, ST_STEPPING} state_t;
  typedef enum logic [2:0] {
    OP_HALT, OP_CONT, OP_STEP, OP_BP_SET, OP_BP_CLR, OP_WP_SET, OP_WP_CLR, OP_RSVD
  } op_t;
  typedef enum logic [1:0] {RSN_HALT, RSN_STEP, RSN_BP, RSN_WP} rsn_t;

  state_t          r_state;
  logic            r_halted;
  logic            r_skip;
  logic            r_evt_vld;
  logic            r_evt_live;
  rsn_t            r_evt_rsn;
  logic [XLEN-1:0] r_evt_adr;
  logic [XLEN-1:0] r_icnt;
  logic [BPN-1:0]  r_bp_en;
  logic [XLEN-1:0] r_bp_adr [BPN];

  op_t  w_op;
  logic w_idx_ok, w_cmd_halt, w_cmd_cont, w_cmd_step, w_bp_set, w_bp_clr;
  logic w_bp_match, w_bp_hit, w_wp_hit, w_cpu_en, w_retire, w_stop;
  rsn_t w_stop_rsn;

  assign w_op       = op_t'(io_bus.cmd_op);
  assign w_idx_ok   = ({1'b0, io_bus.cmd_idx} < (IDXW+1)'(BPN));
  assign w_cmd_halt = io_bus.cmd_vld & (w_op == OP_HALT);
  assign w_cmd_cont = io_bus.cmd_vld & (w_op == OP_CONT);
  assign w_cmd_step = io_bus.cmd_vld & (w_op == OP_STEP);
  assign w_bp_set   = io_bus.cmd_vld & w_idx_ok & (w_op == OP_BP_SET);
  assign w_bp_clr   = io_bus.cmd_vld & w_idx_ok & (w_op == OP_BP_CLR);

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_bp_match = 1'b0;
    for (int i = 0; i < BPN; i++)
      if (r_bp_en[i] && (r_bp_adr[i] == io_bus.ifu_adr)) w_bp_match = 1'b1;
  end

  assign w_bp_hit = io_bus.ifu_trn & w_bp_match & (r_state == ST_RUNNING) & ~r_skip;

`ifdef GDB_RUN_CTRL_WATCH_EN
  logic [BPN-1:0]  r_wp_en;
  logic [XLEN-1:0] r_wp_adr [BPN];
  logic            w_wp_set, w_wp_clr, w_wp_match;

  assign w_wp_set = io_bus.cmd_vld & w_idx_ok & (w_op == OP_WP_SET);
  assign w_wp_clr = io_bus.cmd_vld & w_idx_ok & (w_op == OP_WP_CLR);

  always_comb begin
    w_wp_match = 1'b0;
    for (int i = 0; i < BPN; i++)
      if (r_wp_en[i] && (r_wp_adr[i] == io_bus.lsu_adr)) w_wp_match = 1'b1;
  end

  assign w_wp_hit = io_bus.lsu_trn & io_bus.lsu_wen & w_wp_match & (r_state == ST_RUNNING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_wp_en <= '0;
    else if (w_wp_set) r_wp_en[io_bus.cmd_idx] <= 1'b1;
    else if (w_wp_clr) r_wp_en[io_bus.cmd_idx] <= 1'b0;
  end

  always_ff @(posedge clk)
    if (w_wp_set) r_wp_adr[io_bus.cmd_idx] <= io_bus.cmd_adr;
`else
  assign w_wp_hit = 1'b0;
`endif

  // A hit blocks the instruction; a HALT request lets the current fetch retire.
  assign w_cpu_en = ((r_state == ST_RUNNING) & ~w_bp_hit & ~w_wp_hit) | (r_state == ST_STEPPING);
  assign w_retire = io_bus.ifu_trn & w_cpu_en;

  always_comb begin
    w_stop     = 1'b0;
    w_stop_rsn = RSN_HALT;
    case (r_state)
      ST_RUNNING: begin
        if (w_wp_hit) begin
          w_stop     = 1'b1;
          w_stop_rsn = RSN_WP;
        end else if (w_bp_hit) begin
          w_stop     = 1'b1;
          w_stop_rsn = RSN_BP;
        end else if (w_cmd_halt) begin
          w_stop     = 1'b1;
          w_stop_rsn = RSN_HALT;
        end
      end
      ST_STEPPING: begin
        if (io_bus.ifu_trn) begin
          w_stop     = 1'b1;
          w_stop_rsn = RSN_STEP;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the address table has no reset; r_bp_en alone decides whether a slot can match.
  always_ff @(posedge clk)
    if (w_bp_set) r_bp_adr[io_bus.cmd_idx] <= io_bus.cmd_adr;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HALTED;
      r_halted   <= 1'b1;
      r_skip     <= 1'b0;
      r_evt_vld  <= 1'b0;
      r_evt_live <= 1'b0;
      r_evt_rsn  <= RSN_HALT;
      r_evt_adr  <= '0;
      r_icnt     <= '0;
      r_bp_en    <= '0;
    end else begin
      r_evt_vld  <= 1'b0;
      r_evt_live <= 1'b0;
      if (w_retire) r_icnt <= r_icnt + XLEN'(1);
      if (r_evt_live) r_evt_adr <= io_bus.ifu_adr;

      if (w_bp_set)      r_bp_en[io_bus.cmd_idx] <= 1'b1;
      else if (w_bp_clr) r_bp_en[io_bus.cmd_idx] <= 1'b0;

      if (w_stop) begin
        r_state    <= ST_HALTED;
        r_halted   <= 1'b1;
        r_skip     <= 1'b0;
        r_evt_vld  <= 1'b1;
        r_evt_rsn  <= w_stop_rsn;
        r_evt_adr  <= io_bus.ifu_adr;
        // If the stopping fetch retired, the next PC only appears on ifu_adr one cycle later.
        r_evt_live <= w_retire;
      end else begin
        case (r_state)
          ST_HALTED: begin
            if (w_cmd_cont) begin
              r_state  <= ST_RUNNING;
              r_halted <= 1'b0;
              r_skip   <= 1'b1;
            end else if (w_cmd_step) begin
              r_state  <= ST_STEPPING;
              r_halted <= 1'b0;
            end
          end
          ST_RUNNING: if (w_retire) r_skip <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign io_bus.cmd_rdy = 1'b1;
  assign io_bus.cpu_en  = w_cpu_en;
  assign io_bus.halted  = r_halted;
  assign io_bus.evt_vld = r_evt_vld;
  assign io_bus.evt_rsn = r_evt_rsn;
  assign io_bus.evt_adr = r_evt_live ? io_bus.ifu_adr : r_evt_adr;
  assign io_bus.icnt    = r_icnt;
endmodule

// File: doc/gdb_run_ctrl.md
# gdb_run_ctrl

Run-control sequencer between the GDB server stub and the simulated CPU core. Accepts halt/continue/step and hardware-breakpoint commands from the stub, gates CPU advance through a single enable, compares every instruction fetch against a small breakpoint table, and reports each stop back to the stub as a one-cycle event with reason and stop address. Sits between `gdb_server_stub` (command side) and the core's PC/IFU/LSU (datapath side).

## Interface
- XLEN, 32, address/data width (8/16/32/64)
- BPN, 4, number of hardware breakpoint slots (1..16)
- IDXW, $clog2(BPN) (min 1), slot index width (localparam-style, not overridden)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready, constant 1 (all commands single-cycle)
- cmd_op  in  3  0 HALT, 1 CONT, 2 STEP, 3 BP_SET, 4 BP_CLR, 5 WP_SET, 6 WP_CLR, 7 reserved (no-op)
- cmd_idx  in  IDXW  slot index for *_SET/*_CLR
- cmd_adr  in  XLEN  address for *_SET
- cpu_en  out  1  CPU may advance this cycle (combinational)
- ifu_trn  in  1  instruction fetch transfer
- ifu_adr  in  XLEN  fetch address (current PC)
- halted  out  1  registered, 1 in HALTED state
- evt_vld  out  1  stop event pulse, one cycle
- evt_rsn  out  2  0 HALT request, 1 STEP done, 2 breakpoint, 3 watchpoint
- evt_adr  out  XLEN  ifu_adr at stop (next instruction to execute)
- icnt  out  XLEN  retired-fetch counter
- lsu_trn, lsu_wen (1), lsu_adr (XLEN)  in  only with GDB_RUN_CTRL_WATCH_EN

## Operation
- States: HALTED (reset), RUNNING, STEPPING.
- Command accepted when cmd_vld (cmd_rdy always 1); effect visible next cycle.
- HALTED: CONT -> RUNNING, sets skip flag; STEP -> STEPPING; HALT ignored.
- RUNNING: HALT -> HALTED, evt rsn 0; CONT/STEP ignored.
- STEPPING: all run commands ignored; after exactly one fetch with cpu_en -> HALTED, evt rsn 1.
- BP_SET: bp_adr[idx]<=cmd_adr, bp_en[idx]<=1; BP_CLR: bp_en[idx]<=0. Accepted in any state; idx >= BPN ignored.
- bp_hit = ifu_trn & OR_i(bp_en[i] & bp_adr[i]==ifu_adr) & state==RUNNING & ~skip.
- cpu_en = (RUNNING & ~bp_hit & ~wp_hit) | STEPPING; 0 in HALTED. Hit instruction is never executed.
- bp_hit -> HALTED, evt rsn 2, evt_adr = ifu_adr.
- skip flag: cleared on first fetch with cpu_en after CONT; allows resuming from a breakpoint address. Breakpoints ignored in STEPPING.
- Priority same cycle: watchpoint > breakpoint > HALT command.
- icnt += 1 on each ifu_trn & cpu_en cycle; wraps at 2^XLEN.

## Timing
- Reset: state HALTED, halted=1, cpu_en=0, evt_vld=0, evt_rsn=0, evt_adr=0, icnt=0, bp_en/wp_en all 0, skip=0.
- cpu_en combinational from state and hit (zero latency).
- Stop decision at cycle N -> state HALTED and evt_vld=1 at N+1, evt_vld low at N+2.
- STEP accepted at N: STEPPING at N+1; first ifu_trn cycle M>=N+1 retires one instruction; HALTED+evt at M+1.
- CONT accepted at N: cpu_en high from N+1.
- Reset mid-run: immediate return to reset values; no event emitted.

## Configuration
- GDB_RUN_CTRL_WATCH_EN defined: lsu_* ports present; BPN watch slots; WP_SET/WP_CLR program them; wp_hit = lsu_trn & lsu_wen & match & RUNNING, stops with rsn 3, evt_adr = ifu_adr of stopping cycle; store is suppressed via cpu_en=0.
- Undefined: no lsu ports, WP_SET/WP_CLR accepted as no-ops, wp_hit=0, rsn 3 never produced.

## Test plan
- Reset -> halted=1, cpu_en=0, icnt=0; CONT -> cpu_en=1 next cycle, icnt increments per fetch.
- BP_SET idx0 0x8000_0010, CONT from PC 0x8000_0000 (+4/fetch) -> stop, evt rsn 2, evt_adr 0x8000_0010, icnt 4.
- CONT at breakpoint 0x8000_0010 -> skip passes, runs to 0x8000_0014+; BP_CLR -> no further stops.
- STEP from HALTED at 0x8000_0010 -> exactly one retire, evt rsn 1, evt_adr 0x8000_0014, icnt +1.
- HALT command same cycle as bp hit -> single event, rsn 2; HALT alone in RUNNING -> rsn 0.
- WATCH_EN: WP_SET 0x0000_0100, store to 0x100 -> cpu_en 0 that cycle, evt rsn 3; rst asserted mid-run -> all outputs reset, no evt.
